// File: rtl/fnd_pkg.sv
// Shared types and constants for the 4-digit multiplexed 7-segment scanner.
package fnd_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRIVE = 2'd1,
    ST_BLANK = 2'd2
  } fnd_state_e;

  localparam logic [7:0] SEG_OFF   = 8'hFF;
  localparam logic [3:0] DIGIT_OFF = 4'hF;
  localparam logic [6:0] SEG7_OFF  = 7'h7F;

  // Active-low {g,f,e,d,c,b,a} codes for digits 0-9.
  localparam logic [6:0] SEG_TABLE [10] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
    7'h12, 7'h02, 7'h78, 7'h00, 7'h10
  };

endpackage

// File: rtl/bcd_to_seg.sv
// Combinational BCD nibble to active-low 7-segment code; 10..15 render dark.
module bcd_to_seg
  import fnd_pkg::*;
(
  input  logic [3:0] i_bcd,
  output logic [6:0] o_seg
);

  always_comb begin
    o_seg = SEG7_OFF;
    if (i_bcd <= 4'd9) o_seg = SEG_TABLE[i_bcd];
  end

endmodule

// File: rtl/fnd_scan_controller.sv
// Time-multiplexed 4-digit FND scanner with per-slot blanking and blink masking.
// Optional leading-zero blanking is enabled by defining FND_LEADING_ZERO_BLANK_EN.
module fnd_scan_controller
  import fnd_pkg::*;
#(
  parameter int unsigned SLOT_CYC  = 100000,
  parameter int unsigned BLANK_CYC = 2000
) (
  input  logic        i_clk,
  input  logic        i_reset_n,
  input  logic        i_enable,
  input  logic [15:0] i_bcd,
  input  logic [3:0]  i_dp,
  input  logic [3:0]  i_blink_mask,
  input  logic        i_blink_phase,
  output logic [1:0]  o_digitPosition,
  output logic [3:0]  o_Digit,
  output logic [7:0]  o_font,
  output logic        o_slot_tick
);

  localparam int unsigned     CNT_W      = $clog2(SLOT_CYC);
  localparam logic [CNT_W-1:0] DRIVE_LAST = CNT_W'(SLOT_CYC - BLANK_CYC - 1);
  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYC - 1);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

  fnd_state_e       r_state, w_state_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic [1:0]       r_pos, w_pos_nxt;
  logic             r_tick, w_tick_nxt;
  logic [3:0]       r_digit, w_digit_nxt;
  logic [7:0]       r_font, w_font_nxt;
  logic             w_load;
  logic [3:0]       w_nib;
  logic [6:0]       w_seg;
  logic [6:0]       w_seg_shown;

  assign w_nib = i_bcd[{w_pos_nxt, 2'b00} +: 4];

  bcd_to_seg u_bcd_to_seg (
    .i_bcd (w_nib),
    .o_seg (w_seg)
  );

`ifdef FND_LEADING_ZERO_BLANK_EN
  logic [3:0] w_lz;
  always_comb begin
    w_lz[3] = (i_bcd[15:12] == 4'd0);
    w_lz[2] = w_lz[3] && (i_bcd[11:8] == 4'd0);
    w_lz[1] = w_lz[2] && (i_bcd[7:4] == 4'd0);
    w_lz[0] = 1'b0;
  end
  assign w_seg_shown = w_lz[w_pos_nxt] ? SEG7_OFF : w_seg;
`else
  assign w_seg_shown = w_seg;
`endif

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt + CNT_ONE;
    w_pos_nxt   = r_pos;
    w_tick_nxt  = 1'b0;
    w_load      = 1'b0;
    if (!i_enable) begin
      w_state_nxt = ST_IDLE;
      w_cnt_nxt   = '0;
      w_pos_nxt   = '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          w_state_nxt = ST_DRIVE;
          w_cnt_nxt   = '0;
          w_pos_nxt   = '0;
          w_load      = 1'b1;
        end
        ST_DRIVE: begin
          if (r_cnt == DRIVE_LAST) begin
            w_state_nxt = ST_BLANK;
            w_cnt_nxt   = '0;
          end
        end
        ST_BLANK: begin
          if (r_cnt == BLANK_LAST) begin
            w_state_nxt = ST_DRIVE;
            w_cnt_nxt   = '0;
            w_pos_nxt   = r_pos + 2'd1;
            w_tick_nxt  = 1'b1;
            w_load      = 1'b1;
          end
        end
        default: begin
          w_state_nxt = ST_IDLE;
          w_cnt_nxt   = '0;
          w_pos_nxt   = '0;
        end
      endcase
    end
  end

  // Outputs are computed from next-state so they register on the DRIVE-entry edge;
  // the font loaded at entry is the held sample for the rest of the slot.
  always_comb begin
    w_digit_nxt = DIGIT_OFF;
    w_font_nxt  = SEG_OFF;
    if (w_state_nxt == ST_DRIVE) begin
      if (!(i_blink_phase && i_blink_mask[w_pos_nxt]))
        w_digit_nxt = ~(4'b0001 << w_pos_nxt);
      w_font_nxt = w_load ? {~i_dp[w_pos_nxt], w_seg_shown} : r_font;
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_pos   <= '0;
      r_tick  <= 1'b0;
      r_digit <= DIGIT_OFF;
      r_font  <= SEG_OFF;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_pos   <= w_pos_nxt;
      r_tick  <= w_tick_nxt;
      r_digit <= w_digit_nxt;
      r_font  <= w_font_nxt;
    end
  end

  assign o_digitPosition = r_pos;
  assign o_Digit         = r_digit;
  assign o_font          = r_font;
  assign o_slot_tick     = r_tick;

endmodule

// File: tb/tb_fnd_scan_controller.sv
// Directed self-checking bench for fnd_scan_controller with SLOT_CYC=8, BLANK_CYC=2.
module tb_fnd_scan_controller;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en;
  logic [15:0] bcd;
  logic [3:0]  dp;
  logic [3:0]  bmask;
  logic        bphase;
  logic [1:0]  pos;
  logic [3:0]  dig;
  logic [7:0]  font;
  logic        tick;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fnd_scan_controller #(.SLOT_CYC(8), .BLANK_CYC(2)) dut (
    .i_clk           (clk),
    .i_reset_n       (rst_n),
    .i_enable        (en),
    .i_bcd           (bcd),
    .i_dp            (dp),
    .i_blink_mask    (bmask),
    .i_blink_phase   (bphase),
    .o_digitPosition (pos),
    .o_Digit         (dig),
    .o_font          (font),
    .o_slot_tick     (tick)
  );

  function automatic logic [7:0] efont(input int v, input logic dp_on);
    logic [6:0] s;
    case (v)
      0: s = 7'h40; 1: s = 7'h79; 2: s = 7'h24; 3: s = 7'h30; 4: s = 7'h19;
      5: s = 7'h12; 6: s = 7'h02; 7: s = 7'h78; 8: s = 7'h00; 9: s = 7'h10;
      default: s = 7'h7F;
    endcase
    return {~dp_on, s};
  endfunction

  function automatic logic [3:0] esel(input int slot);
    logic [3:0] one;
    one = 4'b0001 << slot;
    return ~one;
  endfunction

  task automatic restart(input logic [15:0] b, input logic [3:0] d);
    @(negedge clk); en = 1'b0;
    @(negedge clk); bcd = b; dp = d; en = 1'b1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; en = 1'b0; bcd = '0; dp = '0; bmask = '0; bphase = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (dig !== 4'hF)  begin errors++; $display("FAIL reset_digit got=%h exp=F", dig); end
    checks++; if (font !== 8'hFF) begin errors++; $display("FAIL reset_font got=%h exp=FF", font); end
    checks++; if (pos !== 2'd0)  begin errors++; $display("FAIL reset_pos got=%0d exp=0", pos); end
    checks++; if (tick !== 1'b0) begin errors++; $display("FAIL reset_tick got=%b exp=0", tick); end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    checks++; if (dig !== 4'hF) begin errors++; $display("FAIL idle_digit got=%h exp=F", dig); end
    checks++; if (font !== 8'hFF) begin errors++; $display("FAIL idle_font got=%h exp=FF", font); end
  endtask

  task automatic test_scan_and_wrap;
    logic [7:0] f1234 [4];
    logic [3:0] ed;
    logic [7:0] ef;
    int slot, ph, ticks;
    f1234[0] = efont(4, 1'b0); f1234[1] = efont(3, 1'b0);
    f1234[2] = efont(2, 1'b1); f1234[3] = efont(1, 1'b0);
    ticks = 0;
    restart(16'h1234, 4'b0100);
    for (int k = 0; k <= 32; k++) begin
      @(negedge clk);
      slot = (k / 8) % 4; ph = k % 8;
      ed = (ph < 6) ? esel(slot) : 4'hF;
      ef = (ph < 6) ? ((k == 32) ? efont(8, 1'b0) : f1234[slot]) : 8'hFF;
      checks++; if (dig !== ed) begin errors++; $display("FAIL scan_digit k=%0d got=%b exp=%b", k, dig, ed); end
      checks++; if (font !== ef) begin errors++; $display("FAIL scan_font k=%0d got=%h exp=%h", k, font, ef); end
      checks++; if (pos !== 2'(slot)) begin errors++; $display("FAIL scan_pos k=%0d got=%0d exp=%0d", k, pos, slot); end
      checks++; if (tick !== (ph == 0 && k > 0)) begin errors++; $display("FAIL scan_tick k=%0d got=%b", k, tick); end
      if (k > 0 && tick === 1'b1) ticks++;
      if (k == 25) begin bcd = 16'h8888; dp = 4'b0000; end
    end
    checks++; if (ticks != 4) begin errors++; $display("FAIL tick_count got=%0d exp=4", ticks); end
  endtask

  task automatic test_blink;
    logic [3:0] ed;
    int slot, ph;
    bmask = 4'b0011; bphase = 1'b1;
    restart(16'h1234, 4'b0000);
    for (int k = 0; k < 32; k++) begin
      @(negedge clk);
      slot = k / 8; ph = k % 8;
      ed = (ph < 6 && slot >= 2) ? esel(slot) : 4'hF;
      checks++; if (dig !== ed) begin errors++; $display("FAIL blink_digit k=%0d got=%b exp=%b", k, dig, ed); end
      checks++; if (pos !== 2'(slot)) begin errors++; $display("FAIL blink_pos k=%0d got=%0d exp=%0d", k, pos, slot); end
      checks++; if (tick !== (ph == 0 && k > 0)) begin errors++; $display("FAIL blink_tick k=%0d got=%b", k, tick); end
    end
    bmask = 4'b0000; bphase = 1'b0;
  endtask

  task automatic test_disable;
    restart(16'h1234, 4'b0000);
    for (int k = 0; k <= 19; k++) @(negedge clk);
    checks++; if (dig !== 4'b1011) begin errors++; $display("FAIL dis_pre_digit got=%b exp=1011", dig); end
    en = 1'b0;
    @(negedge clk);
    checks++; if (dig !== 4'hF)  begin errors++; $display("FAIL dis_digit got=%h exp=F", dig); end
    checks++; if (font !== 8'hFF) begin errors++; $display("FAIL dis_font got=%h exp=FF", font); end
    checks++; if (pos !== 2'd0)  begin errors++; $display("FAIL dis_pos got=%0d exp=0", pos); end
    checks++; if (tick !== 1'b0) begin errors++; $display("FAIL dis_tick got=%b exp=0", tick); end
    @(negedge clk);
    en = 1'b1;
    @(negedge clk);
    checks++; if (dig !== 4'b1110) begin errors++; $display("FAIL reen_digit got=%b exp=1110", dig); end
    checks++; if (pos !== 2'd0) begin errors++; $display("FAIL reen_pos got=%0d exp=0", pos); end
    checks++; if (font !== efont(4, 1'b0)) begin errors++; $display("FAIL reen_font got=%h exp=%h", font, efont(4, 1'b0)); end
  endtask

  task automatic test_async_reset;
    restart(16'h1234, 4'b0000);
    for (int k = 0; k <= 9; k++) @(negedge clk);
    checks++; if (pos !== 2'd1) begin errors++; $display("FAIL ar_pre_pos got=%0d exp=1", pos); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (dig !== 4'hF)  begin errors++; $display("FAIL ar_digit got=%h exp=F", dig); end
    checks++; if (font !== 8'hFF) begin errors++; $display("FAIL ar_font got=%h exp=FF", font); end
    checks++; if (pos !== 2'd0)  begin errors++; $display("FAIL ar_pos got=%0d exp=0", pos); end
    checks++; if (tick !== 1'b0) begin errors++; $display("FAIL ar_tick got=%b exp=0", tick); end
    @(negedge clk);
    @(negedge clk);
    checks++; if (dig !== 4'hF) begin errors++; $display("FAIL ar_hold_digit got=%h exp=F", dig); end
    rst_n = 1'b1;
    @(negedge clk);
    checks++; if (dig !== 4'b1110) begin errors++; $display("FAIL ar_first_digit got=%b exp=1110", dig); end
    checks++; if (font !== efont(4, 1'b0)) begin errors++; $display("FAIL ar_first_font got=%h exp=%h", font, efont(4, 1'b0)); end
  endtask

  task automatic test_invalid_bcd;
    logic [7:0] ef;
    restart(16'h00FA, 4'b0001);
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      if (k % 8 == 0) begin
        ef = (k == 0) ? 8'h7F : 8'hFF;
        checks++; if (font !== ef) begin errors++; $display("FAIL inv_font k=%0d got=%h exp=%h", k, font, ef); end
        checks++; if (dig !== esel(k / 8)) begin errors++; $display("FAIL inv_digit k=%0d got=%b", k, dig); end
      end
    end
  endtask

  task automatic test_leading_zero;
    logic [7:0] ef [4];
    ef[0] = 8'hC0; ef[1] = 8'h92;
`ifdef FND_LEADING_ZERO_BLANK_EN
    ef[2] = 8'hFF; ef[3] = 8'hFF;
`else
    ef[2] = 8'hC0; ef[3] = 8'hC0;
`endif
    restart(16'h0050, 4'b0000);
    for (int k = 0; k < 32; k++) begin
      @(negedge clk);
      if (k % 8 == 0) begin
        checks++; if (font !== ef[k / 8]) begin errors++; $display("FAIL lz_font k=%0d got=%h exp=%h", k, font, ef[k / 8]); end
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    test_reset;
    test_scan_and_wrap;
    test_blink;
    test_disable;
    test_async_reset;
    test_invalid_bcd;
    test_leading_zero;
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule
